// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back selector.
// Captures the MEM-stage read word and ALU result. It extracts and extends the
// byte or halfword for loads and flags misaligned loads. It registers the
// register-file write port, which also feeds forwarding. It also counts
// retired instructions.
module mem_wb_stage #(
  parameter int CNT_W      = 32,
  parameter int ZERO_GUARD = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_mem,
  input  logic             RegWrite_mem,
  input  logic [1:0]       MemToReg_mem,
  input  logic [2:0]       LoadType_mem,
  input  logic [4:0]       WriteReg_mem,
  input  logic [31:0]      ALUResult_mem,
  input  logic [31:0]      MemReadData,
  input  logic [31:0]      PCPlus4_mem,
  output logic             valid_wb,
  output logic             RegWrite_wb,
  output logic [4:0]       WriteReg_wb,
  output logic [31:0]      WriteData_wb,
  output logic             load_err_wb,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             valid_q, valid_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [1:0]  addr;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        misaligned;
  logic        reg_nonzero;

  assign addr = ALUResult_mem[1:0];

  // The zero-register guard is a build-time choice.
  // When it is disabled, every destination register counts as writable.
  assign reg_nonzero = (ZERO_GUARD == 0) || (WriteReg_mem != 5'd0);

  // Little-endian lane selection and sign/zero extension for loads.
  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = addr[1] ? MemReadData[31:16] : MemReadData[15:0];
    load_data = MemReadData;
    case (addr)
      2'd0:    byte_sel = MemReadData[7:0];
      2'd1:    byte_sel = MemReadData[15:8];
      2'd2:    byte_sel = MemReadData[23:16];
      default: byte_sel = MemReadData[31:24];
    endcase
    case (LoadType_mem)
      LT_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  load_data = {16'h0000, half_sel};
      LT_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  load_data = {24'h000000, byte_sel};
      default: load_data = MemReadData;  // lw and unused encodings
    endcase
  end

  // Alignment is only meaningful for loads.
  // Byte loads can never be misaligned.
  always_comb begin
    misaligned = 1'b0;
    if (MemToReg_mem == WB_LOAD) begin
      case (LoadType_mem)
        LT_LH, LT_LHU: misaligned = addr[0];
        LT_LB, LT_LBU: misaligned = 1'b0;
        default:       misaligned = (addr != 2'b00);
      endcase
    end
  end

  // Next-state selection, in priority order: flush, then stall, then capture.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    instret_d  = instret_q;
    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      wreg_d     = 5'd0;
      wdata_d    = 32'd0;
      err_d      = 1'b0;
    end else if (!stall) begin
      valid_d    = valid_mem;
      regwrite_d = RegWrite_mem & valid_mem & ~misaligned & reg_nonzero;
      wreg_d     = WriteReg_mem;
      err_d      = valid_mem & misaligned;
      if (misaligned) begin
        wdata_d = 32'd0;
      end else begin
        case (MemToReg_mem)
          WB_LOAD: wdata_d = load_data;
          WB_LINK: wdata_d = PCPlus4_mem;
          default: wdata_d = ALUResult_mem;  // ALU and reserved encoding
        endcase
      end
      if (valid_mem && !misaligned) begin
        instret_d = instret_q + CNT_ONE;
      end
    end
  end

  // WB state registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wreg_q     <= 5'd0;
      wdata_q    <= 32'd0;
      err_q      <= 1'b0;
      instret_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      instret_q  <= instret_d;
    end
  end

  assign valid_wb     = valid_q;
  assign RegWrite_wb  = regwrite_q;
  assign WriteReg_wb  = wreg_q;
  assign WriteData_wb = wdata_q;
  assign load_err_wb  = err_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a vector table plus hand-written wrap and reset sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, valid_mem, RegWrite_mem;
  logic [1:0]  MemToReg_mem;
  logic [2:0]  LoadType_mem;
  logic [4:0]  WriteReg_mem;
  logic [31:0] ALUResult_mem, MemReadData, PCPlus4_mem;

  logic        valid_wb, RegWrite_wb, load_err_wb;
  logic [4:0]  WriteReg_wb;
  logic [31:0] WriteData_wb, instret;

  logic        valid_wb4, RegWrite_wb4, load_err_wb4;
  logic [4:0]  WriteReg_wb4;
  logic [31:0] WriteData_wb4;
  logic [3:0]  instret4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_mem(valid_mem), .RegWrite_mem(RegWrite_mem),
    .MemToReg_mem(MemToReg_mem), .LoadType_mem(LoadType_mem),
    .WriteReg_mem(WriteReg_mem), .ALUResult_mem(ALUResult_mem),
    .MemReadData(MemReadData), .PCPlus4_mem(PCPlus4_mem),
    .valid_wb(valid_wb), .RegWrite_wb(RegWrite_wb), .WriteReg_wb(WriteReg_wb),
    .WriteData_wb(WriteData_wb), .load_err_wb(load_err_wb), .instret(instret)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_mem(valid_mem), .RegWrite_mem(RegWrite_mem),
    .MemToReg_mem(MemToReg_mem), .LoadType_mem(LoadType_mem),
    .WriteReg_mem(WriteReg_mem), .ALUResult_mem(ALUResult_mem),
    .MemReadData(MemReadData), .PCPlus4_mem(PCPlus4_mem),
    .valid_wb(valid_wb4), .RegWrite_wb(RegWrite_wb4), .WriteReg_wb(WriteReg_wb4),
    .WriteData_wb(WriteData_wb4), .load_err_wb(load_err_wb4), .instret(instret4)
  );

  typedef struct {
    string       name;
    logic        stall, flush, valid, rw;
    logic [1:0]  m2r;
    logic [2:0]  lt;
    logic [4:0]  wr;
    logic [31:0] alu, rd, pc4;
    logic        e_valid, e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_err;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic v, input logic rw,
                       input logic [1:0] m2r, input logic [2:0] lt, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc4);
    stall = s; flush = f; valid_mem = v; RegWrite_mem = rw; MemToReg_mem = m2r;
    LoadType_mem = lt; WriteReg_mem = wr; ALUResult_mem = alu; MemReadData = rd;
    PCPlus4_mem = pc4;
  endtask

  task automatic addv(input string n, input logic s, input logic f, input logic v, input logic rw,
                      input logic [1:0] m2r, input logic [2:0] lt, input logic [4:0] wr,
                      input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc4,
                      input logic ev, input logic erw, input logic [4:0] ewr,
                      input logic [31:0] ewd, input logic eerr, input logic [31:0] ecnt);
    vec_t t;
    t.name = n; t.stall = s; t.flush = f; t.valid = v; t.rw = rw; t.m2r = m2r; t.lt = lt;
    t.wr = wr; t.alu = alu; t.rd = rd; t.pc4 = pc4;
    t.e_valid = ev; t.e_rw = erw; t.e_wr = ewr; t.e_wd = ewd; t.e_err = eerr; t.e_cnt = ecnt;
    vecs.push_back(t);
  endtask

  localparam logic [31:0] W = 32'h8000F0A5;

  initial begin
    // name          st fl v rw m2r    lt    wr     alu           rd  pc4            v rw wr     wd            err cnt
    addv("lw_al",     0, 0, 1, 1, 2'b01, 3'd0, 5'd8,  32'h10,       W, 32'h0,         1, 1, 5'd8,  W,            0, 1);
    addv("lb_11",     0, 0, 1, 1, 2'b01, 3'd3, 5'd9,  32'h11,       W, 32'h0,         1, 1, 5'd9,  32'hFFFFFFF0, 0, 2);
    addv("lbu_11",    0, 0, 1, 1, 2'b01, 3'd4, 5'd9,  32'h11,       W, 32'h0,         1, 1, 5'd9,  32'h000000F0, 0, 3);
    addv("lh_12",     0, 0, 1, 1, 2'b01, 3'd1, 5'd9,  32'h12,       W, 32'h0,         1, 1, 5'd9,  32'hFFFF8000, 0, 4);
    addv("lhu_10",    0, 0, 1, 1, 2'b01, 3'd2, 5'd9,  32'h10,       W, 32'h0,         1, 1, 5'd9,  32'h0000F0A5, 0, 5);
    addv("lw_mis",    0, 0, 1, 1, 2'b01, 3'd0, 5'd10, 32'h12,       W, 32'h0,         1, 0, 5'd10, 32'h0,        1, 5);
    addv("lh_mis",    0, 0, 1, 1, 2'b01, 3'd1, 5'd10, 32'h11,       W, 32'h0,         1, 0, 5'd10, 32'h0,        1, 5);
    addv("lb_13",     0, 0, 1, 1, 2'b01, 3'd3, 5'd11, 32'h13,       W, 32'h0,         1, 1, 5'd11, 32'hFFFFFF80, 0, 6);
    addv("addi_r0",   0, 0, 1, 1, 2'b00, 3'd0, 5'd0,  32'h5,        W, 32'h0,         1, 0, 5'd0,  32'h5,        0, 7);
    addv("alu_m2r11", 0, 0, 1, 1, 2'b11, 3'd0, 5'd5,  32'h1234,     W, 32'h0,         1, 1, 5'd5,  32'h1234,     0, 8);
    addv("bubble",    0, 0, 0, 1, 2'b00, 3'd0, 5'd6,  32'h7,        W, 32'h0,         0, 0, 5'd6,  32'h7,        0, 8);
    addv("bubble_mis",0, 0, 0, 1, 2'b01, 3'd0, 5'd3,  32'h2,        W, 32'h0,         0, 0, 5'd3,  32'h0,        0, 8);
    addv("jal",       0, 0, 1, 1, 2'b10, 3'd0, 5'd31, 32'h99,       W, 32'h00400008,  1, 1, 5'd31, 32'h00400008, 0, 9);
    addv("stall1",    1, 0, 1, 1, 2'b00, 3'd0, 5'd4,  32'hAAAA,     W, 32'h0,         1, 1, 5'd31, 32'h00400008, 0, 9);
    addv("stall2",    1, 0, 1, 1, 2'b01, 3'd0, 5'd4,  32'h13,       W, 32'h0,         1, 1, 5'd31, 32'h00400008, 0, 9);
    addv("stall3",    1, 0, 0, 0, 2'b00, 3'd0, 5'd4,  32'hBBBB,     W, 32'h0,         1, 1, 5'd31, 32'h00400008, 0, 9);
    addv("stallflush",1, 1, 1, 1, 2'b00, 3'd0, 5'd4,  32'hCCCC,     W, 32'h0,         0, 0, 5'd0,  32'h0,        0, 9);
    addv("lhu_12",    0, 0, 1, 1, 2'b01, 3'd2, 5'd12, 32'h12,       W, 32'h0,         1, 1, 5'd12, 32'h00008000, 0, 10);
    addv("flush",     0, 1, 1, 1, 2'b00, 3'd0, 5'd4,  32'hDDDD,     W, 32'h0,         0, 0, 5'd0,  32'h0,        0, 10);
    addv("lt7_mis",   0, 0, 1, 1, 2'b01, 3'd7, 5'd13, 32'h11,       W, 32'h0,         1, 0, 5'd13, 32'h0,        1, 10);
    addv("lt5_lw",    0, 0, 1, 1, 2'b01, 3'd5, 5'd14, 32'h10,       W, 32'h0,         1, 1, 5'd14, W,            0, 11);

    drive(0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid_wb}, 32'd0);
    chk("rst_data", WriteData_wb, 32'd0);
    chk("rst_cnt", instret, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven section: drive at negedge, sample 1 time unit after the posedge.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].rw, vecs[i].m2r, vecs[i].lt,
            vecs[i].wr, vecs[i].alu, vecs[i].rd, vecs[i].pc4);
      @(posedge clk);
      #1;
      chk({vecs[i].name, ".valid"}, {31'd0, valid_wb}, {31'd0, vecs[i].e_valid});
      chk({vecs[i].name, ".rw"}, {31'd0, RegWrite_wb}, {31'd0, vecs[i].e_rw});
      chk({vecs[i].name, ".wr"}, {27'd0, WriteReg_wb}, {27'd0, vecs[i].e_wr});
      chk({vecs[i].name, ".wd"}, WriteData_wb, vecs[i].e_wd);
      chk({vecs[i].name, ".err"}, {31'd0, load_err_wb}, {31'd0, vecs[i].e_err});
      chk({vecs[i].name, ".cnt"}, instret, vecs[i].e_cnt);
      chk({vecs[i].name, ".cnt4"}, {28'd0, instret4}, {28'd0, vecs[i].e_cnt[3:0]});
      $display("vec %0d %s wd=0x%08h rw=%0b err=%0b cnt=%0d", i, vecs[i].name,
               WriteData_wb, RegWrite_wb, load_err_wb, instret);
      @(negedge clk);
    end

    // Wrap sequence: 16 retirements bring the 4-bit counter back to 0.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 1, 1, 2'b00, 3'd0, 5'd1, k, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      if (k == 14) chk("wrap.pre", {28'd0, instret4}, 32'd15);
      @(negedge clk);
    end
    chk("wrap.cnt4", {28'd0, instret4}, 32'd0);
    chk("wrap.cnt32", instret, 32'd16);
    $display("wrap cnt4=%0d cnt32=%0d", instret4, instret);

    // Asynchronous reset mid-cycle clears outputs before the next edge.
    drive(0, 0, 1, 1, 2'b10, 3'd0, 5'd7, 32'h0, 32'h0, 32'h0000ABCD);
    @(posedge clk);
    #2;
    chk("pre_rst.wd", WriteData_wb, 32'h0000ABCD);
    reset = 1'b1;
    #1;
    chk("async.valid", {31'd0, valid_wb}, 32'd0);
    chk("async.rw", {31'd0, RegWrite_wb}, 32'd0);
    chk("async.wr", {27'd0, WriteReg_wb}, 32'd0);
    chk("async.wd", WriteData_wb, 32'd0);
    chk("async.cnt", instret, 32'd0);
    $display("async reset wd=0x%08h cnt=%0d", WriteData_wb, instret);
    // First capture happens on the first rising edge with reset low.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst.wd", WriteData_wb, 32'h0000ABCD);
    chk("post_rst.cnt", instret, 32'd1);
    $display("post reset wd=0x%08h cnt=%0d", WriteData_wb, instret);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and write-back selector for the 5-stage pipelined CPU.
- Captures the combined memory/peripheral/UART read word and the ALU result at the end of MEM.
- Performs load byte/halfword extraction and sign/zero extension, flags misaligned loads, and selects register-file write data.
- Drives register-file write and forwarding sources; keeps a retired-instruction counter.

Parameters:
- CNT_W, 32: width of retired-instruction counter.
- ZERO_GUARD, 1: when 1, writes to register 0 are suppressed at capture.

Ports:
- clk  input  1  CPU clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold all WB state this cycle.
- flush  input  1  load a bubble into WB this cycle.
- valid_mem  input  1  MEM-stage instruction is real (not a bubble).
- RegWrite_mem  input  1  instruction writes the register file.
- MemToReg_mem  input  2  write-back source: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as 00).
- LoadType_mem  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; others treated as lw.
- WriteReg_mem  input  5  destination register number.
- ALUResult_mem  input  32  ALU result / load address.
- MemReadData  input  32  combined read word from MEM (RAM|peripheral|UART).
- PCPlus4_mem  input  32  link address for jal/jalr.
- valid_wb  output  1  WB holds a real instruction.
- RegWrite_wb  output  1  register-file write enable.
- WriteReg_wb  output  5  register-file write address.
- WriteData_wb  output  32  register-file write data, also the forwarding source.
- load_err_wb  output  1  WB instruction was a misaligned load.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, immediate): every output and internal register goes to 0.
- Update priority on each rising clk: reset > flush > stall > capture.
- Flush: valid_wb, RegWrite_wb and load_err_wb go to 0. WriteReg_wb and WriteData_wb go to 0. instret is unchanged. Flush wins over a simultaneous stall.
- Stall without flush: all registers hold, including instret. Outputs are stable for as many cycles as stall stays high.
- Capture (normal): latency is exactly 1 cycle from MEM inputs to WB outputs. All outputs are registered; nothing is combinational from the inputs.
- Load extraction, little-endian, using addr = ALUResult_mem[1:0]:
  - lb/lbu: byte addr selects bits [8*addr+7 : 8*addr]; lb sign-extends bit 7 of the byte, lbu zero-extends.
  - lh/lhu: addr[1]=0 selects [15:0], addr[1]=1 selects [31:16]; lh sign-extends, lhu zero-extends.
  - lw: full word.
- Misalignment is checked only when MemToReg_mem=01:
  - lw with addr != 00, or lh/lhu with addr[0]=1, is misaligned.
  - Misaligned load: load_err_wb=1, RegWrite_wb=0, WriteData_wb=0.
  - Byte loads are never misaligned.
- Write-data mux: 00/11 -> ALUResult_mem; 01 -> extracted load; 10 -> PCPlus4_mem.
- RegWrite_wb is set to RegWrite_mem & valid_mem & ~misaligned, and additionally & (WriteReg_mem != 0) when ZERO_GUARD=1.
- valid_wb is set to valid_mem.
- instret increments by 1 on a capture edge when valid_mem=1 and the load is not misaligned. It wraps from 2^CNT_W-1 to 0 with no flag.
- Bubble capture (valid_mem=0): valid_wb=0, RegWrite_wb=0, load_err_wb=0. Data fields are still captured but have no effect.
- Reset asserted mid-stall or mid-flush clears immediately. The first capture after reset release occurs on the first rising edge with reset low.

Test Plan:
- lw aligned: ALUResult=0x00000010, MemReadData=0x8000F0A5, LoadType=000, MemToReg=01, WriteReg=8, RegWrite=1 -> next cycle WriteData_wb=0x8000F0A5, RegWrite_wb=1, WriteReg_wb=8, instret=1.
- Byte/half extension: word 0x8000F0A5.
  - lb at addr 0x11 -> 0xFFFFFFF0.
  - lbu at 0x11 -> 0x000000F0.
  - lh at 0x12 -> 0xFFFF8000.
  - lhu at 0x10 -> 0x0000F0A5.
- Misaligned: lw at 0x12 -> load_err_wb=1, RegWrite_wb=0, WriteData_wb=0, instret unchanged.
- lh at 0x11 -> load_err_wb=1.
- Hazard controls:
  - stall high 3 cycles after a jal capture (PCPlus4=0x00400008, WriteReg=31) -> outputs hold 0x00400008/31 for 3 cycles, instret +1 only once.
  - stall and flush together -> bubble: valid_wb=0, RegWrite_wb=0.
- Zero guard: addi targeting register 0 with RegWrite=1, ALUResult=5 -> RegWrite_wb=0, valid_wb=1, instret increments.
- Reset and wrap:
  - instret preset near wrap via CNT_W=4: 16 retirements -> instret returns to 0.
  - Assert reset asynchronously mid-cycle -> all outputs 0 before the next clk edge.
